// File: rtl/pe_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_scheduler_if
//  Purpose  : Bundles the layer-controller handshake, per-channel counts and
//             the PE issue bus of the sparse-conv PE scheduler.
//  Modports : master - layer controller / PE side (drives start, counts,
//                      pe_ready; observes the issue bus and status)
//             slave  - the scheduler itself
//  Revision : 1.0  initial release
// ============================================================================
interface pe_scheduler_if #(
    parameter int LANES = 4,
    parameter int IDX_W = 16,
    parameter int CH_W  = 16
) ();
    // Layer controller -> scheduler
    logic              start;
    logic [CH_W-1:0]   num_channels;
    logic [IDX_W-1:0]  feature_valid_num;
    logic [IDX_W-1:0]  weight_valid_num;
    // PE -> scheduler
    logic              pe_ready;
    // Scheduler -> PE operand selection
    logic              pe_in_valid;
    logic [CH_W-1:0]   pe_channel;
    logic [IDX_W-1:0]  weight_idx;
    logic [IDX_W-1:0]  pixel_idx;
    logic [LANES-1:0]  lane_mask;
    logic              last_pair;
    // Scheduler -> layer controller
    logic              busy;
    logic              done;

    modport master (
        output start, num_channels, feature_valid_num, weight_valid_num, pe_ready,
        input  pe_in_valid, pe_channel, weight_idx, pixel_idx, lane_mask,
               last_pair, busy, done
    );

    modport slave (
        input  start, num_channels, feature_valid_num, weight_valid_num, pe_ready,
        output pe_in_valid, pe_channel, weight_idx, pixel_idx, lane_mask,
               last_pair, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pe_scheduler
//  Purpose  : Sequencer for the sparse-conv PE datapath. For every input
//             channel it walks all (nonzero weight, group of LANES nonzero
//             pixels) pairs, pixel loop inner / weight loop outer, and issues
//             them to the PE with a valid/ready handshake.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous reset, active low
//             bus  - pe_scheduler_if.slave:
//                    start/num_channels in, per-channel feature/weight counts
//                    in (sampled in LOAD), pe_ready in; pe_in_valid,
//                    pe_channel, weight_idx, pixel_idx, lane_mask, last_pair,
//                    busy, done out
//  Revision : 1.0  initial release
// ============================================================================
module pe_scheduler #(
    parameter int LANES = 4,
    parameter int IDX_W = 16,
    parameter int CH_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pe_scheduler_if.slave       bus
);

    localparam logic [IDX_W:0] c_LANES = (IDX_W+1)'(LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [CH_W-1:0]    r_num_ch;
    logic [CH_W-1:0]    r_channel;
    logic [IDX_W-1:0]   r_f;
    logic [IDX_W-1:0]   r_w;
    logic [IDX_W-1:0]   r_weight_idx;
    logic [IDX_W-1:0]   r_pixel_idx;
    logic [LANES-1:0]   r_lane_mask;
    logic               r_pe_in_valid;
    logic               r_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [CH_W-1:0]    w_num_ch_nxt;
    logic [CH_W-1:0]    w_channel_nxt;
    logic [IDX_W-1:0]   w_f_nxt;
    logic [IDX_W-1:0]   w_w_nxt;
    logic [IDX_W-1:0]   w_weight_idx_nxt;
    logic [IDX_W-1:0]   w_pixel_idx_nxt;
    logic               w_valid_nxt;
    logic               w_advance;
    logic [LANES-1:0]   w_lane_raw_nxt;
    logic [LANES-1:0]   w_lane_mask_nxt;

    // ------------------------------------------------------------------
    // Decodes from registers. One extra bit keeps pixel_idx+LANES and
    // index+1 from wrapping when F or W is at its maximum value.
    // ------------------------------------------------------------------
    logic [IDX_W:0]     w_pixel_sum;
    logic               w_pix_end;
    logic               w_w_last;
    logic               w_ch_last;
    logic               w_accept;

    assign w_pixel_sum = {1'b0, r_pixel_idx} + c_LANES;
    assign w_pix_end   = (w_pixel_sum >= {1'b0, r_f});
    assign w_w_last    = (({1'b0, r_weight_idx} + (IDX_W+1)'(1)) == {1'b0, r_w});
    assign w_ch_last   = (({1'b0, r_channel} + (CH_W+1)'(1)) == {1'b0, r_num_ch});
    assign w_accept    = r_pe_in_valid && bus.pe_ready;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_num_ch_nxt     = r_num_ch;
        w_channel_nxt    = r_channel;
        w_f_nxt          = r_f;
        w_w_nxt          = r_w;
        w_weight_idx_nxt = r_weight_idx;
        w_pixel_idx_nxt  = r_pixel_idx;
        w_valid_nxt      = 1'b0;
        w_advance        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_num_ch_nxt  = bus.num_channels;
                    w_channel_nxt = '0;
                    w_state_nxt   = (bus.num_channels == '0) ? ST_DONE : ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_f_nxt          = bus.feature_valid_num;
                w_w_nxt          = bus.weight_valid_num;
                w_weight_idx_nxt = '0;
                w_pixel_idx_nxt  = '0;
                if ((bus.feature_valid_num == '0) || (bus.weight_valid_num == '0)) begin
                    // Empty channel: nothing to issue, move straight on.
                    w_advance = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                w_valid_nxt = 1'b1;
                if (w_accept) begin
                    if (w_pix_end) begin
                        w_pixel_idx_nxt  = '0;
                        w_weight_idx_nxt = r_weight_idx + IDX_W'(1);
                    end else begin
                        w_pixel_idx_nxt  = w_pixel_sum[IDX_W-1:0];
                    end
                    if (w_w_last && w_pix_end) begin
                        w_advance        = 1'b1;
                        w_valid_nxt      = 1'b0;
                        w_pixel_idx_nxt  = '0;
                        w_weight_idx_nxt = '0;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Channel advance, shared by the skip path in LOAD and the final
        // accepted pair in RUN.
        if (w_advance) begin
            if (w_ch_last) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_channel_nxt = r_channel + CH_W'(1);
                w_state_nxt   = ST_LOAD;
            end
        end
    end

    // Lane i is live when its pixel lies below the channel's nonzero count.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lane_raw_nxt[gi] =
            (({1'b0, w_pixel_idx_nxt} + (IDX_W+1)'(gi)) < {1'b0, w_f_nxt});
    end

    assign w_lane_mask_nxt = w_valid_nxt ? w_lane_raw_nxt : '0;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_num_ch      <= '0;
            r_channel     <= '0;
            r_f           <= '0;
            r_w           <= '0;
            r_weight_idx  <= '0;
            r_pixel_idx   <= '0;
            r_lane_mask   <= '0;
            r_pe_in_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_num_ch      <= w_num_ch_nxt;
            r_channel     <= w_channel_nxt;
            r_f           <= w_f_nxt;
            r_w           <= w_w_nxt;
            r_weight_idx  <= w_weight_idx_nxt;
            r_pixel_idx   <= w_pixel_idx_nxt;
            r_lane_mask   <= w_lane_mask_nxt;
            r_pe_in_valid <= w_valid_nxt;
            // The done pulse is registered off the DONE state, so it shows
            // up two cycles after the last accepted pair (or after start for
            // an empty layer). A reset during DONE therefore suppresses it.
            r_done        <= (r_state == ST_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pe_in_valid = r_pe_in_valid;
    assign bus.pe_channel  = r_channel;
    assign bus.weight_idx  = r_weight_idx;
    assign bus.pixel_idx   = r_pixel_idx;
    assign bus.lane_mask   = r_lane_mask;
    assign bus.last_pair   = r_pe_in_valid && w_w_last && w_pix_end;
    assign bus.busy        = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_scheduler
//  Purpose  : Self-checking bench for pe_scheduler. Expected issue streams
//             come from a nested-loop model of the channel/weight/pixel walk.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_scheduler;

    localparam int LANES = 4;
    localparam int IDX_W = 16;
    localparam int CH_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pe_scheduler_if #(.LANES(LANES), .IDX_W(IDX_W), .CH_W(CH_W)) bus ();

    pe_scheduler #(.LANES(LANES), .IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int ch;
        int w;
        int p;
        int mask;
        bit last;
    } iss_t;

    typedef struct {
        int f;
        int w;
        int n;      // expected issue count
        int lp;     // pixel_idx of last issue (-1: none)
        int lm;     // lane_mask of last issue
        int dc;     // cycle (after start) where done is seen
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   f_arr [8];
    int   w_arr [8];
    iss_t exp_q [$];

    int   t_issues, t_dones, t_done_cyc, t_first, t_last_p, t_last_m;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: every channel, every nonzero weight, every LANES-wide group.
    task automatic build_expected(input int nch);
        iss_t e;
        exp_q.delete();
        for (int c = 0; c < nch; c++)
            for (int w = 0; w < w_arr[c]; w++)
                for (int p = 0; p < f_arr[c]; p += LANES) begin
                    e.ch   = c;
                    e.w    = w;
                    e.p    = p;
                    e.mask = 0;
                    for (int i = 0; i < LANES; i++)
                        if (p + i < f_arr[c]) e.mask |= (1 << i);
                    e.last = (w == w_arr[c] - 1) && (p + LANES >= f_arr[c]);
                    exp_q.push_back(e);
                end
    endtask

    task automatic drive_counts();
        int idx;
        idx = int'(bus.pe_channel);
        bus.feature_valid_num = (idx < 8) ? IDX_W'(f_arr[idx]) : '0;
        bus.weight_valid_num  = (idx < 8) ? IDX_W'(w_arr[idx]) : '0;
    endtask

    // mode 0: pe_ready always 1; 1: random; 2: 1,0,0,1 pattern over RUN cycles.
    // poke_k >= 0 re-asserts start (with a different channel count) at that cycle.
    task automatic run_layer(input int nch, input int mode, input int poke_k);
        int   k;
        int   budget;
        int   pi;
        bit   pat [4];
        iss_t e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        build_expected(nch);
        t_issues = 0; t_dones = 0; t_done_cyc = -1; t_first = -1;
        t_last_p = -1; t_last_m = 0;
        budget = 100 + 3 * exp_q.size();
        pi = 0;
        k  = 0;
        bus.num_channels = CH_W'(nch);
        bus.start        = 1'b1;
        bus.pe_ready     = 1'b1;
        drive_counts();
        while (1) begin
            @(negedge clk);
            k++;
            bus.start = (k == poke_k);
            if (k == poke_k) bus.num_channels = CH_W'(5);
            drive_counts();
            case (mode)
                1:       bus.pe_ready = 1'($urandom_range(0, 1));
                2:       begin
                             bus.pe_ready = bus.pe_in_valid ? pat[pi % 4] : 1'b1;
                             if (bus.pe_in_valid) pi++;
                         end
                default: bus.pe_ready = 1'b1;
            endcase

            if (bus.done) begin
                t_dones++;
                if (t_done_cyc < 0) t_done_cyc = k;
                chk("busy_at_done", bus.busy, 0);
            end
            if (t_done_cyc >= 0 && k > t_done_cyc)
                chk("busy_after_done", bus.busy, 0);

            if (bus.pe_in_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_issue", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("issue_ch",   bus.pe_channel, e.ch);
                    chk("issue_w",    bus.weight_idx, e.w);
                    chk("issue_p",    bus.pixel_idx,  e.p);
                    chk("issue_mask", bus.lane_mask,  e.mask);
                    chk("issue_last", bus.last_pair,  e.last);
                    if (bus.pe_ready) begin
                        void'(exp_q.pop_front());
                        t_issues++;
                        if (t_first < 0) t_first = k;
                        t_last_p = e.p;
                        t_last_m = e.mask;
                    end
                end
            end else begin
                chk("idle_mask", bus.lane_mask, 0);
                chk("idle_last", bus.last_pair, 0);
            end

            if (t_done_cyc >= 0 && k >= t_done_cyc + 3) break;
            if (k > budget) begin
                chk("timeout", k, budget);
                break;
            end
        end
        chk("leftover_issues", exp_q.size(), 0);
        chk("done_count", t_dones, 1);
    endtask

    vec_t tbl [9];

    initial begin
        int found;
        int nch;

        tbl[0] = '{8,     3, 6,     4,     15, 9};
        tbl[1] = '{6,     1, 2,     4,     3,  5};
        tbl[2] = '{1,     1, 1,     0,     1,  4};
        tbl[3] = '{5,     2, 4,     4,     1,  7};
        tbl[4] = '{3,     0, 0,     -1,    0,  3};
        tbl[5] = '{0,     5, 0,     -1,    0,  3};
        tbl[6] = '{9,     1, 3,     8,     1,  6};
        tbl[7] = '{7,     1, 2,     4,     7,  5};
        tbl[8] = '{65535, 1, 16384, 65532, 7,  16387};

        bus.start = 1'b0;
        bus.num_channels = '0;
        bus.feature_valid_num = '0;
        bus.weight_valid_num = '0;
        bus.pe_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin f_arr[i] = 0; w_arr[i] = 0; end

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",   bus.pe_in_valid, 0);
        chk("rst_channel", bus.pe_channel,  0);
        chk("rst_widx",    bus.weight_idx,  0);
        chk("rst_pidx",    bus.pixel_idx,   0);
        chk("rst_mask",    bus.lane_mask,   0);
        chk("rst_busy",    bus.busy,        0);
        chk("rst_done",    bus.done,        0);
        rst = 1'b1;
        @(negedge clk);

        // Single-channel table, ready always high
        for (int i = 0; i < 9; i++) begin
            f_arr[0] = tbl[i].f;
            w_arr[0] = tbl[i].w;
            run_layer(1, 0, -1);
            chk($sformatf("tbl%0d_issues", i),   t_issues,   tbl[i].n);
            chk($sformatf("tbl%0d_last_p", i),   t_last_p,   tbl[i].lp);
            chk($sformatf("tbl%0d_last_m", i),   t_last_m,   tbl[i].lm);
            chk($sformatf("tbl%0d_done_cyc", i), t_done_cyc, tbl[i].dc);
            if (tbl[i].n > 0) chk($sformatf("tbl%0d_first", i), t_first, 2);
        end

        // Middle channel skipped (W=0)
        f_arr[0] = 4; w_arr[0] = 2;
        f_arr[1] = 4; w_arr[1] = 0;
        f_arr[2] = 4; w_arr[2] = 2;
        run_layer(3, 0, -1);
        chk("skip_issues",   t_issues,   4);
        chk("skip_done_cyc", t_done_cyc, 9);

        // Back-pressure 1,0,0,1
        f_arr[0] = 8; w_arr[0] = 1;
        run_layer(1, 2, -1);
        chk("bp_issues",   t_issues,   2);
        chk("bp_done_cyc", t_done_cyc, 7);

        // Empty layer
        run_layer(0, 0, -1);
        chk("nch0_issues",   t_issues,   0);
        chk("nch0_done_cyc", t_done_cyc, 2);

        // start while busy must be ignored
        f_arr[0] = 4; w_arr[0] = 1;
        run_layer(1, 0, 2);
        chk("poke_issues",   t_issues,   1);
        chk("poke_done_cyc", t_done_cyc, 4);

        // Randomized layers with random back-pressure
        for (int r = 0; r < 8; r++) begin
            nch = $urandom_range(1, 4);
            for (int c = 0; c < 8; c++) begin
                f_arr[c] = $urandom_range(0, 13);
                w_arr[c] = $urandom_range(0, 4);
            end
            run_layer(nch, 1, -1);
        end

        // Reset in the middle of channel 1 of 3
        for (int c = 0; c < 3; c++) begin f_arr[c] = 8; w_arr[c] = 2; end
        bus.num_channels = CH_W'(3);
        bus.start    = 1'b1;
        bus.pe_ready = 1'b1;
        drive_counts();
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            drive_counts();
            if (bus.pe_in_valid && bus.pe_channel == CH_W'(1)) begin
                found = 1;
                break;
            end
        end
        chk("reached_ch1", found, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_valid",   bus.pe_in_valid, 0);
        chk("mid_rst_channel", bus.pe_channel,  0);
        chk("mid_rst_widx",    bus.weight_idx,  0);
        chk("mid_rst_pidx",    bus.pixel_idx,   0);
        chk("mid_rst_mask",    bus.lane_mask,   0);
        chk("mid_rst_last",    bus.last_pair,   0);
        chk("mid_rst_busy",    bus.busy,        0);
        chk("mid_rst_done",    bus.done,        0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_done",  bus.done,        0);
            chk("post_rst_busy",  bus.busy,        0);
            chk("post_rst_valid", bus.pe_in_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
